uidbuf_rd_flip_engine: RTL and testbench

//  Read-side frame-buffer engine with runtime-selectable orientation: 0 deg, H-mirror, V-flip, 180 deg.

---
 rtl/uidbuf_rd_flip_engine.sv | 172 +++++++++++++++++
 tb/tb_uidbuf_rd_flip_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uidbuf_rd_flip_engine.sv
// uidbuf_rd_flip_engine: fetches a frame line by line from FDMA into a ping-pong line buffer
// and drains it as a pixel stream, optionally mirrored horizontally and/or flipped vertically.
module uidbuf_rd_flip_engine #(
    parameter int          AXI_DATA_WIDTH = 128,
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          PIX_WIDTH      = 16,
    parameter int          H_PIX          = 640,
    parameter int          V_LINES        = 480,
    parameter int          LINE_STRIDE_B  = 1280,
    parameter int unsigned BASEADDR       = 0,
    parameter int          BUF_BITS       = 24
) (
    input  logic                      I_ui_clk,
    input  logic                      I_ui_rstn,
    input  logic                      I_fs,
    input  logic [1:0]                I_mode,
    input  logic [7:0]                I_rbuf,
    output logic [AXI_ADDR_WIDTH-1:0] O_fdma_raddr,
    output logic                      O_fdma_rareq,
    output logic [15:0]               O_fdma_rsize,
    input  logic                      I_fdma_rbusy,
    input  logic [AXI_DATA_WIDTH-1:0] I_fdma_rdata,
    input  logic                      I_fdma_rvalid,
    output logic                      O_fdma_rready,
    output logic [PIX_WIDTH-1:0]      O_pix_data,
    output logic                      O_pix_valid,
    input  logic                      I_pix_ready,
    output logic                      O_pix_sol,
    output logic                      O_pix_eof,
    output logic                      O_frame_done,
    output logic                      O_fs_ovr,
    output logic                      O_busy
);
    localparam int W   = H_PIX * PIX_WIDTH / AXI_DATA_WIDTH;
    localparam int PPW = AXI_DATA_WIDTH / PIX_WIDTH;
    localparam int LW  = $clog2(V_LINES + 1);
    localparam int CW  = $clog2(W + 1);
    localparam int WW  = W > 1 ? $clog2(W) : 1;
    localparam int PW  = PPW > 1 ? $clog2(PPW) : 1;
    localparam int MW  = $clog2(2 * W);

    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_REQ, F_XFER} fstate_t;
    typedef enum logic {D_IDLE, D_RUN} dstate_t;

    fstate_t f_q, f_d;
    dstate_t d_q, d_d;
    logic [1:0] mode, full;
    logic [7:0] rbuf;
    logic [LW-1:0] fl, il, src;
    logic [CW-1:0] cnt;
    logic [WW-1:0] iw, rw;
    logic [PW-1:0] ip, psel;
    logic [BUF_BITS-1:0] off;
    logic [AXI_ADDR_WIDTH-1:0] raddr;
    logic [AXI_DATA_WIDTH-1:0] mem [0:2*W-1];
    logic [PPW-1:0][PIX_WIDTH-1:0] rd_word;
    logic accept, hs, ilast, issue, we, xfer_done, cb;
    logic pv, psol, peof, plast;
    logic ov, osol, oeof, olast, sv, ssol, seof, slast;
    logic [PIX_WIDTH-1:0] odata, sdata;

    assign accept    = I_fs && !O_busy;
    assign hs        = ov && I_pix_ready;
    assign ilast     = iw == WW'(W - 1) && ip == PW'(PPW - 1);
    assign issue     = d_q == D_RUN && full[il[0]] && (int'(ov) + int'(sv) + int'(pv) - int'(hs)) <= 1;
    assign we        = f_q == F_XFER && I_fdma_rvalid && cnt < CW'(W);
    assign xfer_done = f_q == F_XFER && cnt == CW'(W) && !I_fdma_rbusy;
    assign src       = mode[1] ? LW'(V_LINES - 1) - fl : fl;
    assign off       = BUF_BITS'(src) * BUF_BITS'(LINE_STRIDE_B);
    assign rw        = mode[0] ? WW'(W - 1) - iw : iw;

    assign O_fdma_raddr  = raddr;
    assign O_fdma_rareq  = f_q == F_REQ;
    assign O_fdma_rsize  = 16'(W);
    assign O_fdma_rready = 1'b1;
    assign O_pix_data    = odata;
    assign O_pix_valid   = ov;
    assign O_pix_sol     = osol;
    assign O_pix_eof     = oeof;

    always_ff @(posedge I_ui_clk or negedge I_ui_rstn)
        if (!I_ui_rstn) begin
            f_q <= F_IDLE;
            d_q <= D_IDLE;
        end else begin
            f_q <= f_d;
            d_q <= d_d;
        end

    always_comb begin
        f_d = f_q;
        case (f_q)
            F_IDLE:  f_d = accept ? F_WAIT : F_IDLE;
            F_WAIT:  f_d = fl == LW'(V_LINES) ? F_IDLE : !full[fl[0]] ? F_REQ : F_WAIT;
            F_REQ:   f_d = I_fdma_rbusy ? F_XFER : F_REQ;
            F_XFER:  f_d = xfer_done ? F_WAIT : F_XFER;
            default: f_d = F_IDLE;
        endcase
        d_d = d_q == D_IDLE ? (accept ? D_RUN : D_IDLE)
                            : (issue && ilast && il == LW'(V_LINES - 1) ? D_IDLE : D_RUN);
    end

    // Line RAM: no reset, read registered on issue.
    always_ff @(posedge I_ui_clk) begin
        if (we)
            mem[MW'(int'(fl[0]) * W + int'(cnt))] <= I_fdma_rdata;
        if (issue)
            rd_word <= mem[MW'(int'(il[0]) * W + int'(rw))];
    end

    always_ff @(posedge I_ui_clk or negedge I_ui_rstn)
        if (!I_ui_rstn) begin
            O_busy <= 1'b0;
            O_frame_done <= 1'b0;
            O_fs_ovr <= 1'b0;
            mode <= '0;
            rbuf <= '0;
            raddr <= '0;
            fl <= '0;
            cnt <= '0;
            full <= '0;
            cb <= 1'b0;
            iw <= '0;
            ip <= '0;
            il <= '0;
            {pv, psol, peof, plast, psel} <= '0;
            {ov, osol, oeof, olast, odata} <= '0;
            {sv, ssol, seof, slast, sdata} <= '0;
        end else begin
            O_busy <= accept | (O_busy & ~(hs & oeof));
            O_frame_done <= hs & oeof;
            O_fs_ovr <= I_fs & O_busy;
            if (accept) begin
                mode <= I_mode;
                rbuf <= I_rbuf;
                fl <= '0;
                cb <= 1'b0;
                iw <= '0;
                ip <= '0;
                il <= '0;
            end
            if (f_q == F_WAIT && f_d == F_REQ)
                raddr <= AXI_ADDR_WIDTH'(BASEADDR) + AXI_ADDR_WIDTH'({rbuf, off});
            cnt <= f_q == F_REQ ? '0 : we ? cnt + 1'b1 : cnt;
            if (xfer_done)
                fl <= fl + 1'b1;
            // Fill and drain never target the same bank in one cycle.
            full <= (full | (xfer_done ? 2'b01 << fl[0] : 2'b00)) & ~(hs && olast ? 2'b01 << cb : 2'b00);
            if (hs && olast)
                cb <= ~cb;
            if (issue) begin
                ip <= ip == PW'(PPW - 1) ? '0 : ip + 1'b1;
                iw <= ilast ? '0 : ip == PW'(PPW - 1) ? iw + 1'b1 : iw;
                il <= ilast ? il + 1'b1 : il;
            end
            pv <= issue;
            psel <= mode[0] ? PW'(PPW - 1) - ip : ip;
            psol <= iw == '0 && ip == '0;
            plast <= ilast;
            peof <= ilast && il == LW'(V_LINES - 1);
            // Output register backed by a one-entry skid absorbs the RAM latency under stall.
            if (!ov || hs) begin
                ov <= sv | pv;
                {odata, osol, oeof, olast} <= sv ? {sdata, ssol, seof, slast} : {rd_word[psel], psol, peof, plast};
                sv <= sv & pv;
                {sdata, ssol, seof, slast} <= {rd_word[psel], psol, peof, plast};
            end else if (pv) begin
                sv <= 1'b1;
                {sdata, ssol, seof, slast} <= {rd_word[psel], psol, peof, plast};
            end
        end
endmodule

// File: tb/tb_uidbuf_rd_flip_engine.sv
// tb_uidbuf_rd_flip_engine: directed frames in all four orientations against an FDMA responder,
// with backpressure, overlapping frame-start and mid-burst reset.
module tb_uidbuf_rd_flip_engine;
    logic        clk = 0, rstn = 0, fs = 0, rbusy = 0, rvalid = 0, ready = 1;
    logic [1:0]  mode = 0;
    logic [7:0]  rbuf = 0;
    logic [127:0] rdata = '0;
    logic [31:0] raddr;
    logic        rareq, rready, valid, sol, eof, frame_done, fs_ovr, busy;
    logic [15:0] rsize, data;

    int checks = 0, failures = 0, done_cnt = 0, ovr_cnt = 0;
    bit rnd = 0, stall_arm = 0, seen_l1 = 0, extra = 0, pend = 0, prev_stall = 0;
    logic [15:0] pdata;
    logic psol, peof;
    logic [31:0] addr_q[$];
    logic [17:0] pix_q[$];

    uidbuf_rd_flip_engine #(
        .AXI_DATA_WIDTH(128), .AXI_ADDR_WIDTH(32), .PIX_WIDTH(16), .H_PIX(16), .V_LINES(4),
        .LINE_STRIDE_B(32), .BASEADDR(0), .BUF_BITS(24)
    ) dut (
        .I_ui_clk(clk), .I_ui_rstn(rstn), .I_fs(fs), .I_mode(mode), .I_rbuf(rbuf),
        .O_fdma_raddr(raddr), .O_fdma_rareq(rareq), .O_fdma_rsize(rsize), .I_fdma_rbusy(rbusy),
        .I_fdma_rdata(rdata), .I_fdma_rvalid(rvalid), .O_fdma_rready(rready),
        .O_pix_data(data), .O_pix_valid(valid), .I_pix_ready(ready), .O_pix_sol(sol),
        .O_pix_eof(eof), .O_frame_done(frame_done), .O_fs_ovr(fs_ovr), .O_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_req", 32'({rareq, rready, valid, sol, eof}), 32'b01000);
        check("rst_flags", 32'({frame_done, fs_ovr, busy}), 32'd0);
        check("rst_raddr", raddr, 32'd0);
        check("rst_rsize", 32'(rsize), 32'd2);
        check("rst_data", 32'(data), 32'd0);
    endtask

    // FDMA responder: memory pixel(l,x) = 16*l + x, optional junk beat past W.
    initial begin
        logic [7:0][15:0] beat;
        int l;
        forever begin
            @(posedge clk); #1;
            if (rareq) begin
                addr_q.push_back(raddr);
                l = int'(raddr[23:0]) / 32;
                rbusy = 1;
                for (int b = 0; b < (extra ? 3 : 2); b++) begin
                    @(posedge clk); #1;
                    for (int p = 0; p < 8; p++)
                        beat[p] = b < 2 ? 16'(16 * l + 8 * b + p) : 16'hDEAD;
                    rdata = beat;
                    rvalid = 1;
                end
                @(posedge clk); #1;
                rvalid = 0;
                rbusy = 0;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (stall_arm && seen_l1) begin
            ready = 0;
            repeat (100) @(posedge clk);
            check("no_rareq_l3", 32'(addr_q.size()), 32'd3);
            stall_arm = 0;
        end else
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            prev_stall = 0;
            pend = 0;
        end else begin
            if (frame_done) done_cnt++;
            if (fs_ovr) ovr_cnt++;
            if (pend) begin
                check("frame_done", 32'(frame_done), 32'd1);
                check("busy_clr", 32'(busy), 32'd0);
                pend = 0;
            end
            if (prev_stall)
                check("stall_hold", 32'({valid, sol, eof, data}), 32'({1'b1, psol, peof, pdata}));
            prev_stall = valid && !ready;
            {psol, peof, pdata} = {sol, eof, data};
            if (valid && ready) begin
                pix_q.push_back({sol, eof, data});
                if (eof) pend = 1;
                if (stall_arm && sol && data == 16'd16) seen_l1 = 1;
            end
        end
    end

    task automatic run_frame(input logic [1:0] m, input logic [7:0] rb, input bit chk_start);
        int d0;
        int src, px;
        addr_q.delete();
        pix_q.delete();
        @(posedge clk); #1;
        mode = m;
        rbuf = rb;
        fs = 1;
        @(posedge clk); #1;
        fs = 0;
        if (chk_start) begin
            @(negedge clk);
            check("busy_set", 32'(busy), 32'd1);
            check("rareq_c1", 32'(rareq), 32'd0);
            @(negedge clk);
            check("rareq_c2", 32'(rareq), 32'd1);
        end
        d0 = done_cnt;
        for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge clk);
        @(negedge clk);
        check("done_cnt", 32'(done_cnt - d0), 32'd1);
        check("addr_n", 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++)
            check("raddr", addr_q[i], {rb, 24'((m[1] ? 3 - i : i) * 32)});
        check("pix_n", 32'(pix_q.size()), 32'd64);
        for (int k = 0; k < 64 && k < pix_q.size(); k++) begin
            src = m[1] ? 3 - k / 16 : k / 16;
            px = m[0] ? 15 - k % 16 : k % 16;
            check("pix", 32'(pix_q[k]), 32'({k % 16 == 0, k == 63, 16'(16 * src + px)}));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rstn = 1;
        run_frame(2'd0, 8'd0, 1);
        extra = 1;
        run_frame(2'd1, 8'd0, 0);
        extra = 0;
        run_frame(2'd2, 8'd0, 0);
        run_frame(2'd3, 8'd2, 0);
        rnd = 1;
        stall_arm = 1;
        run_frame(2'd0, 8'd0, 0);
        rnd = 0;
        check("stall_hit", 32'(stall_arm), 32'd0);
        ovr_cnt = 0;
        fork
            run_frame(2'd0, 8'd0, 0);
            begin
                repeat (30) @(posedge clk);
                #1 fs = 1;
                @(posedge clk); #1;
                fs = 0;
            end
        join
        check("fs_ovr", 32'(ovr_cnt), 32'd1);
        @(posedge clk); #1;
        fs = 1;
        @(posedge clk); #1;
        fs = 0;
        for (int i = 0; i < 50 && !rvalid; i++) @(negedge clk);
        check("xfer_seen", 32'(rvalid), 32'd1);
        #1 rstn = 0;
        #1 check_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        repeat (20) @(posedge clk);
        run_frame(2'd0, 8'd0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
